// File: rtl/keypad_entry.sv
// keypad_entry: keypad time-entry stage for the microwave.
// Debounces one-hot keypad presses, accepts each press once, and shifts
// the decoded digit into a 3-digit BCD cook time (mins:sec_tens:sec_ones).
// Optional feature macro: ENTRY_ROLLOVER_EN -- when defined, presses after
// the third digit keep shifting (oldest digit dropped) instead of being
// rejected with key_err.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keypad,
    input  logic       load_en,
    input  logic       consume,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] digit_count,
    output logic       entry_valid,
    output logic       key_err
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        ARMED    = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    state_t           state;
    logic [9:0]       kp_q;
    logic [9:0]       kp_prev;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             accept;
    logic [3:0]       new_digit;
    logic             multi_key;

    // Decode a one-hot key code: bit k (k=0..8) is digit k+1, bit9 is digit 0.
    function automatic logic [3:0] encode(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (k[i]) d = 4'(i + 1);
        end
        return d;
    endfunction

    // Number of keys pressed at once.
    function automatic logic [3:0] popcount(input logic [9:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, k[i]};
        end
        return n;
    endfunction

    // Stable also requires the sample to match its predecessor, so a fresh
    // key value never rides on a counter still saturated from the old value.
    assign stable    = (cnt == CNT_MAX) && (kp_q == kp_prev);
    assign accept    = (state == ARMED) && (kp_q != 10'd0) && stable;
    assign new_digit = encode(kp_q);
    assign multi_key = (popcount(kp_q) > 4'd1);

    // Register the keypad and count consecutive identical samples.
    always_ff @(posedge clk) begin
        if (clear) begin
            kp_q    <= 10'd0;
            kp_prev <= 10'd0;
            cnt     <= '0;
        end else begin
            kp_q    <= keypad;
            kp_prev <= kp_q;
            if (kp_q != kp_prev) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Press FSM plus the digit shift register and reject pulse.
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= WAIT_REL;
            mins        <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 2'd0;
            key_err     <= 1'b0;
        end else begin
            key_err <= 1'b0;

            case (state)
                WAIT_REL: if (kp_q == 10'd0 && stable) state <= ARMED;
                ARMED:    if (accept) state <= HELD;
                HELD:     if (kp_q == 10'd0 && stable) state <= ARMED;
                default:  state <= WAIT_REL;
            endcase

            if (consume) begin
                // The timer took the digits; a press landing on this edge is lost.
                mins        <= 4'd0;
                sec_tens    <= 4'd0;
                sec_ones    <= 4'd0;
                digit_count <= 2'd0;
            end else if (accept && load_en) begin
                if (multi_key) begin
                    key_err <= 1'b1;
                end else if (digit_count != 2'd3) begin
                    mins        <= sec_tens;
                    sec_tens    <= sec_ones;
                    sec_ones    <= new_digit;
                    digit_count <= digit_count + 2'd1;
                end else begin
`ifdef ENTRY_ROLLOVER_EN
                    mins     <= sec_tens;
                    sec_tens <= sec_ones;
                    sec_ones <= new_digit;
`else
                    key_err <= 1'b1;
`endif
                end
            end
        end
    end

    assign entry_valid = (digit_count != 2'd0) && (sec_tens <= 4'd5);

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry.
// Stimulus pushes the expected output snapshot for every press that should
// visibly change the outputs; the monitor pops and compares whenever the
// digits/count change or key_err pulses.
module tb_keypad_entry;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       load_en;
    logic       consume;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] digit_count;
    logic       entry_valid;
    logic       key_err;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] st;
        logic [3:0] so;
        logic [1:0] cnt;
        logic       vld;
        logic       err;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    keypad_entry #(.DEBOUNCE_CYCLES(2), .CNT_W(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .keypad      (keypad),
        .load_en     (load_en),
        .consume     (consume),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .digit_count (digit_count),
        .entry_valid (entry_valid),
        .key_err     (key_err)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] kv(input int d);
        logic [9:0] v;
        v = 10'd0;
        if (d == 0) v[9] = 1'b1;
        else        v[d-1] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input logic [3:0] m, input logic [3:0] st, input logic [3:0] so,
                               input logic [1:0] c, input logic v, input logic e);
        snap_t s;
        s.m = m; s.st = st; s.so = so; s.cnt = c; s.vld = v; s.err = e;
        exp_q.push_back(s);
    endtask

    task automatic press(input logic [9:0] k);
        keypad = k;
        repeat (4) tick();
        keypad = 10'd0;
        repeat (4) tick();
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        tick();
        consume = 1'b0;
        tick();
    endtask

    // Monitor: compare against the scoreboard whenever the outputs move.
    snap_t prev_s;
    always @(negedge clk) begin
        snap_t cur;
        snap_t e;
        cur = '{m: mins, st: sec_tens, so: sec_ones, cnt: digit_count, vld: entry_valid, err: key_err};
        if (mon_en) begin
            if (key_err && prev_s.err) begin
                checks++;
                errors++;
                $display("FAIL key_err_double: key_err high two cycles in a row, required single pulse");
            end
            if (cur.err || cur.m != prev_s.m || cur.st != prev_s.st || cur.so != prev_s.so
                || cur.cnt != prev_s.cnt) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %0d:%0d%0d cnt=%0d vld=%0b err=%0b, required no change",
                             cur.m, cur.st, cur.so, cur.cnt, cur.vld, cur.err);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        errors++;
                        $display("FAIL event: got %0d:%0d%0d cnt=%0d vld=%0b err=%0b, required %0d:%0d%0d cnt=%0d vld=%0b err=%0b",
                                 cur.m, cur.st, cur.so, cur.cnt, cur.vld, cur.err,
                                 e.m, e.st, e.so, e.cnt, e.vld, e.err);
                    end
                end
            end
        end
        prev_s = cur;
    end

    initial begin
        clear   = 1'b1;
        keypad  = 10'd0;
        load_en = 1'b1;
        consume = 1'b0;
        repeat (2) tick();
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if ({mins, sec_tens, sec_ones, digit_count, entry_valid, key_err} != 17'd0) begin
            errors++;
            $display("FAIL reset: got %0d:%0d%0d cnt=%0d vld=%0b err=%0b, required all zero",
                     mins, sec_tens, sec_ones, digit_count, entry_valid, key_err);
        end
        mon_en = 1'b1;
        repeat (4) tick();

        // 1,4,5 -> 1:45
        expect_snap(0, 0, 1, 1, 1, 0); press(kv(1));
        expect_snap(0, 1, 4, 2, 1, 0); press(kv(4));
        expect_snap(1, 4, 5, 3, 1, 0); press(kv(5));
        expect_snap(0, 0, 0, 0, 0, 0); pulse_consume();

        // 9,0 -> 0:90, tens digit out of range so not valid
        expect_snap(0, 0, 9, 1, 1, 0); press(kv(9));
        expect_snap(0, 9, 0, 2, 0, 0); press(kv(0));
        expect_snap(0, 0, 0, 0, 0, 0); pulse_consume();

        // Long hold gives one accept; a one-cycle glitch gives none.
        expect_snap(0, 0, 3, 1, 1, 0);
        keypad = kv(3);
        repeat (20) tick();
        keypad = 10'd0;
        repeat (4) tick();
        keypad = kv(5);
        tick();
        keypad = 10'd0;
        repeat (6) tick();

        // Two keys at once rejected; load_en low drops the press silently.
        expect_snap(0, 0, 3, 1, 1, 1); press(10'b0000001001);
        load_en = 1'b0;
        press(kv(7));
        load_en = 1'b1;
        expect_snap(0, 0, 0, 0, 0, 0); pulse_consume();

        // Fourth digit after 1,2,3.
        expect_snap(0, 0, 1, 1, 1, 0); press(kv(1));
        expect_snap(0, 1, 2, 2, 1, 0); press(kv(2));
        expect_snap(1, 2, 3, 3, 1, 0); press(kv(3));
`ifdef ENTRY_ROLLOVER_EN
        expect_snap(2, 3, 4, 3, 1, 0); press(kv(4));
`else
        expect_snap(1, 2, 3, 3, 1, 1); press(kv(4));
`endif
        expect_snap(0, 0, 0, 0, 0, 0); pulse_consume();

        // Clear while a key is mid-debounce: held key must be released first.
        expect_snap(0, 0, 1, 1, 1, 0); press(kv(1));
        keypad = kv(2);
        repeat (2) tick();
        expect_snap(0, 0, 0, 0, 0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        keypad = 10'd0;
        repeat (4) tick();
        expect_snap(0, 0, 2, 1, 1, 0); press(kv(2));

        repeat (6) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
